// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone B4 classic arbiter.
// Bus widths, default watchdog limit and FSM state encoding.
package wb_arb_pkg;

    localparam int WB_AW   = 32;
    localparam int WB_DW   = 32;
    localparam int WB_SELW = 4;

    localparam int unsigned TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN0  = 2'd1,
        OWN1  = 2'd2,
        DRAIN = 2'd3
    } arb_state_t;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Saturating 8-bit wait counter for a stalled slave access.
// Fires for one cycle when the count reaches TIMEOUT while enabled.
module wb_arb_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr,
    input  logic en,
    output logic fire
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT);

    logic [7:0] cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr) begin
            cnt <= 8'd0;
        end else if (en && cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign fire = en && (cnt == LIMIT);

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin two-master / one-slave Wishbone B4 classic arbiter.
// Grant is held for a whole cyc; a watchdog aborts hung accesses.
module wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,

    input  logic               m0_cyc_i,
    input  logic               m0_stb_i,
    input  logic               m0_we_i,
    input  logic [WB_AW-1:0]   m0_addr_i,
    input  logic [WB_DW-1:0]   m0_dat_i,
    input  logic [WB_SELW-1:0] m0_sel_i,
    output logic [WB_DW-1:0]   m0_dat_o,
    output logic               m0_ack_o,
    output logic               m0_err_o,

    input  logic               m1_cyc_i,
    input  logic               m1_stb_i,
    input  logic               m1_we_i,
    input  logic [WB_AW-1:0]   m1_addr_i,
    input  logic [WB_DW-1:0]   m1_dat_i,
    input  logic [WB_SELW-1:0] m1_sel_i,
    output logic [WB_DW-1:0]   m1_dat_o,
    output logic               m1_ack_o,
    output logic               m1_err_o,

    output logic               s_cyc_o,
    output logic               s_stb_o,
    output logic               s_we_o,
    output logic [WB_AW-1:0]   s_addr_o,
    output logic [WB_DW-1:0]   s_dat_o,
    output logic [WB_SELW-1:0] s_sel_o,
    input  logic [WB_DW-1:0]   s_dat_i,
    input  logic               s_ack_i,
    input  logic               s_err_i,

    output logic [1:0]         gnt_o
);

    arb_state_t state_q, state_d;
    logic       last_q, last_d;
    logic       own0, own1;
    logic       wd_en, wd_fire;

    assign own0 = (state_q == OWN0);
    assign own1 = (state_q == OWN1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
                    state_d = OWN0;
                    last_d  = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d = OWN1;
                    last_d  = 1'b1;
                end
            end
            OWN0: begin
                if (!m0_cyc_i)    state_d = IDLE;
                else if (wd_fire) state_d = DRAIN;
            end
            OWN1: begin
                if (!m1_cyc_i)    state_d = IDLE;
                else if (wd_fire) state_d = DRAIN;
            end
            DRAIN: begin
                // last still names the aborted owner here
                if (!(last_q ? m1_cyc_i : m0_cyc_i)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_addr_o = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        if (own0) begin
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_stb_i;
            s_we_o   = m0_we_i;
            s_addr_o = m0_addr_i;
            s_dat_o  = m0_dat_i;
            s_sel_o  = m0_sel_i;
        end else if (own1) begin
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_stb_i;
            s_we_o   = m1_we_i;
            s_addr_o = m1_addr_i;
            s_dat_o  = m1_dat_i;
            s_sel_o  = m1_sel_i;
        end
    end

    // Reset suppresses any response to the access being aborted
    assign m0_ack_o = own0 && s_ack_i && !rst_i;
    assign m1_ack_o = own1 && s_ack_i && !rst_i;
    assign m0_err_o = own0 && (s_err_i || wd_fire) && !rst_i;
    assign m1_err_o = own1 && (s_err_i || wd_fire) && !rst_i;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign gnt_o    = {own1, own0};

    assign wd_en = s_stb_o && !s_ack_i && !s_err_i;

    wb_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wd (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr   (!wd_en),
        .en    (wd_en),
        .fire  (wd_fire)
    );

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with TIMEOUT=4.
// Inputs change 1ns after posedge; outputs sampled on negedge.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m0_cyc = 0, m0_stb = 0, m0_we = 0;
    logic [31:0] m0_addr = 0, m0_wdat = 0;
    logic [3:0]  m0_sel = 0;
    logic [31:0] m0_rdat;
    logic        m0_ack, m0_err;
    logic        m1_cyc = 0, m1_stb = 0, m1_we = 0;
    logic [31:0] m1_addr = 0, m1_wdat = 0;
    logic [3:0]  m1_sel = 0;
    logic [31:0] m1_rdat;
    logic        m1_ack, m1_err;
    logic        s_cyc, s_stb, s_we;
    logic [31:0] s_addr, s_wdat;
    logic [3:0]  s_sel;
    logic [31:0] s_rdat = 0;
    logic        s_ack = 0, s_err = 0;
    logic [1:0]  gnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    wb_arbiter #(.TIMEOUT(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we),
        .m0_addr_i(m0_addr), .m0_dat_i(m0_wdat), .m0_sel_i(m0_sel),
        .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we),
        .m1_addr_i(m1_addr), .m1_dat_i(m1_wdat), .m1_sel_i(m1_sel),
        .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
        .s_addr_o(s_addr), .s_dat_o(s_wdat), .s_sel_o(s_sel),
        .s_dat_i(s_rdat), .s_ack_i(s_ack), .s_err_i(s_err),
        .gnt_o(gnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        tests++;
    endtask

    task automatic release_all();
        m0_cyc = 0; m0_stb = 0; m0_we = 0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0;
        s_ack = 0; s_err = 0;
        tick();
        tick();
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        release_all();
        do_reset();
        s_rdat = 32'hA5A5_5A5A;
        sample();
        if ({gnt, s_cyc, s_stb, s_we} !== 5'b0) begin
            $display("FAIL reset_ctrl: got %b want 00000", {gnt, s_cyc, s_stb, s_we});
            fails++;
        end
        sample();
        if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0) begin
            $display("FAIL reset_resp: got %b want 0000", {m0_ack, m0_err, m1_ack, m1_err});
            fails++;
        end
        sample();
        if (s_addr !== 0 || s_wdat !== 0 || s_sel !== 0) begin
            $display("FAIL reset_bus: got %h %h %h want 0", s_addr, s_wdat, s_sel);
            fails++;
        end
        sample();
        if (m0_rdat !== 32'hA5A5_5A5A || m1_rdat !== 32'hA5A5_5A5A) begin
            $display("FAIL reset_rdat: got %h %h want a5a55a5a", m0_rdat, m1_rdat);
            fails++;
        end
    endtask

    task automatic test_m0_write();
        tick();
        m0_cyc = 1; m0_stb = 1; m0_we = 1;
        m0_addr = 32'h100; m0_wdat = 32'hDEAD_BEEF; m0_sel = 4'hF;
        sample();
        if (s_cyc !== 1'b0 || gnt !== 2'b00) begin
            $display("FAIL wr_c0: got cyc=%b gnt=%b want 0 00", s_cyc, gnt);
            fails++;
        end
        tick();
        sample();
        if ({s_cyc, s_stb, s_we, s_addr, s_wdat, s_sel, gnt}
            !== {3'b111, 32'h100, 32'hDEAD_BEEF, 4'hF, 2'b01}) begin
            $display("FAIL wr_c1: got %b%b%b %h %h %h gnt=%b want 111 100 deadbeef f 01",
                     s_cyc, s_stb, s_we, s_addr, s_wdat, s_sel, gnt);
            fails++;
        end
        tick();
        sample();
        if (m0_ack !== 1'b0) begin
            $display("FAIL wr_c2_ack: got %b want 0", m0_ack);
            fails++;
        end
        tick();
        s_ack = 1;
        sample();
        if (m0_ack !== 1'b1 || m1_ack !== 1'b0 || gnt !== 2'b01) begin
            $display("FAIL wr_c3_ack: got m0=%b m1=%b gnt=%b want 1 0 01", m0_ack, m1_ack, gnt);
            fails++;
        end
        tick();
        s_ack = 0;
        m0_cyc = 0; m0_stb = 0;
        sample();
        if (m0_ack !== 1'b0) begin
            $display("FAIL wr_c4_ack: got %b want 0", m0_ack);
            fails++;
        end
        tick();
        sample();
        if (gnt !== 2'b00 || s_cyc !== 1'b0) begin
            $display("FAIL wr_release: got gnt=%b cyc=%b want 00 0", gnt, s_cyc);
            fails++;
        end
        release_all();
    endtask

    task automatic test_tie();
        do_reset();
        m0_cyc = 1; m1_cyc = 1;
        tick();
        sample();
        if (gnt !== 2'b01) begin
            $display("FAIL tie_first: got %b want 01", gnt);
            fails++;
        end
        tick();
        m0_cyc = 0;
        tick();
        sample();
        if (gnt !== 2'b00) begin
            $display("FAIL tie_bubble: got %b want 00", gnt);
            fails++;
        end
        tick();
        m0_cyc = 1;
        sample();
        if (gnt !== 2'b10) begin
            $display("FAIL tie_second: got %b want 10", gnt);
            fails++;
        end
        tick();
        m1_cyc = 0;
        sample();
        if (gnt !== 2'b10) begin
            $display("FAIL tie_hold: got %b want 10", gnt);
            fails++;
        end
        tick();
        m1_cyc = 1;
        tick();
        sample();
        if (gnt !== 2'b01) begin
            $display("FAIL tie_rr: got %b want 01", gnt);
            fails++;
        end
        release_all();
    endtask

    task automatic test_m1_read();
        tick();
        m1_cyc = 1; m1_stb = 1; m1_we = 0;
        m1_addr = 32'h200; m1_sel = 4'hF;
        tick();
        sample();
        if (gnt !== 2'b10 || s_addr !== 32'h200 || s_we !== 1'b0) begin
            $display("FAIL rd_grant: got gnt=%b addr=%h we=%b want 10 200 0", gnt, s_addr, s_we);
            fails++;
        end
        tick();
        s_ack = 1; s_rdat = 32'h1234_5678;
        sample();
        if (m1_rdat !== 32'h1234_5678 || m1_ack !== 1'b1 || m0_ack !== 1'b0) begin
            $display("FAIL rd_ack: got dat=%h m1=%b m0=%b want 12345678 1 0",
                     m1_rdat, m1_ack, m0_ack);
            fails++;
        end
        release_all();
    endtask

    task automatic test_watchdog();
        tick();
        m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_addr = 32'h300;
        tick();
        tick();
        tick();
        tick();
        sample();
        if (m0_err !== 1'b0 || gnt !== 2'b01) begin
            $display("FAIL wd_early: got err=%b gnt=%b want 0 01", m0_err, gnt);
            fails++;
        end
        tick();
        sample();
        if (m0_err !== 1'b1 || m1_err !== 1'b0) begin
            $display("FAIL wd_fire: got m0=%b m1=%b want 1 0", m0_err, m1_err);
            fails++;
        end
        tick();
        m1_cyc = 1;
        sample();
        if (s_cyc !== 1'b0 || m0_err !== 1'b0) begin
            $display("FAIL wd_drain: got cyc=%b err=%b want 0 0", s_cyc, m0_err);
            fails++;
        end
        tick();
        sample();
        if (s_cyc !== 1'b0 || gnt[1] !== 1'b0) begin
            $display("FAIL wd_hold: got cyc=%b gnt=%b want 0 0x", s_cyc, gnt);
            fails++;
        end
        m0_cyc = 0; m0_stb = 0;
        tick();
        tick();
        sample();
        if (gnt !== 2'b10) begin
            $display("FAIL wd_exit: got %b want 10", gnt);
            fails++;
        end
        release_all();
    endtask

    task automatic test_slave_err();
        tick();
        m1_cyc = 1; m1_stb = 1; m1_we = 1;
        m1_addr = 32'h400; m1_wdat = 32'h0BAD_F00D; m1_sel = 4'h3;
        tick();
        tick();
        s_err = 1;
        sample();
        if (m1_err !== 1'b1 || m0_err !== 1'b0) begin
            $display("FAIL serr_fwd: got m1=%b m0=%b want 1 0", m1_err, m0_err);
            fails++;
        end
        tick();
        s_err = 0;
        sample();
        if (gnt !== 2'b10 || m1_err !== 1'b0) begin
            $display("FAIL serr_keep: got gnt=%b err=%b want 10 0", gnt, m1_err);
            fails++;
        end
        tick();
        tick();
        sample();
        if (m1_err !== 1'b0) begin
            $display("FAIL serr_wdclr5: got %b want 0", m1_err);
            fails++;
        end
        tick();
        sample();
        if (m1_err !== 1'b0) begin
            $display("FAIL serr_wdclr6: got %b want 0", m1_err);
            fails++;
        end
        tick();
        sample();
        if (m1_err !== 1'b1) begin
            $display("FAIL serr_wdfire: got %b want 1", m1_err);
            fails++;
        end
        release_all();
    endtask

    task automatic test_reset_mid();
        tick();
        m1_cyc = 1; m1_stb = 1; m1_we = 1;
        m1_addr = 32'h500; m1_wdat = 32'h5555_AAAA; m1_sel = 4'hF;
        tick();
        sample();
        if (gnt !== 2'b10) begin
            $display("FAIL rst_pre: got %b want 10", gnt);
            fails++;
        end
        tick();
        rst = 1;
        m0_cyc = 1;
        tick();
        rst = 0;
        sample();
        if ({gnt, s_cyc, s_stb, s_we} !== 5'b0 || s_addr !== 0 || s_wdat !== 0 || s_sel !== 0) begin
            $display("FAIL rst_abort: got gnt=%b %b%b%b %h %h %h want all 0",
                     gnt, s_cyc, s_stb, s_we, s_addr, s_wdat, s_sel);
            fails++;
        end
        tick();
        sample();
        if (gnt !== 2'b01) begin
            $display("FAIL rst_tie: got %b want 01", gnt);
            fails++;
        end
        release_all();
    endtask

    initial begin
        test_reset();
        test_m0_write();
        test_tie();
        test_m1_read();
        test_watchdog();
        test_slave_err();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
